// File: rtl/bcd_pkg.sv
// Shared BCD datapath definitions: digit width, digit limit, FSM states and validity helper.
package bcd_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CORR,
        DONE
    } state_t;

    function automatic logic is_bcd(input logic [DIGIT_W-1:0] nibble);
        return nibble <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// One-digit BCD subtract with borrow: d = x - y - bin, wrapped into 0..9.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    input  logic               bin,
    output logic [DIGIT_W-1:0] d,
    output logic               bout
);

    logic signed [DIGIT_W:0] t;
    logic signed [DIGIT_W:0] t_adj;

    // Valid digits keep t within -10..9, so the sign bit is the borrow.
    always_comb begin
        t     = $signed({1'b0, x}) - $signed({1'b0, y}) - $signed({{DIGIT_W{1'b0}}, bin});
        t_adj = t + $signed((DIGIT_W + 1)'(10));
        bout  = t[DIGIT_W];
        d     = bout ? t_adj[DIGIT_W-1:0] : t[DIGIT_W-1:0];
    end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor, diff = a - b, LSD first, start/busy/done handshake.
// Optional BCD_SUB_SIGN_MAG_EN: negative results are re-complemented to sign-magnitude.
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [DIGIT_W*DIGITS-1:0]   a,
    input  logic [DIGIT_W*DIGITS-1:0]   b,
    output logic                        busy,
    output logic                        done,
    output logic [DIGIT_W*DIGITS-1:0]   diff,
    output logic                        borrow,
    output logic                        invalid
);

    localparam int unsigned W     = DIGIT_W * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               br_q, br_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic               invalid_q, invalid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [DIGIT_W-1:0] dig_x, dig_y, dig_d;
    logic               dig_bout;
    logic               any_bad;
    logic               last;

    // Operand select for the shared digit slice.
    always_comb begin
        dig_x = '0;
        dig_y = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                dig_x = a_q[i*DIGIT_W +: DIGIT_W];
                dig_y = b_q[i*DIGIT_W +: DIGIT_W];
`ifdef BCD_SUB_SIGN_MAG_EN
                if (state_q == CORR) begin
                    dig_x = '0;
                    dig_y = diff_q[i*DIGIT_W +: DIGIT_W];
                end
`endif
            end
        end
    end

    bcd_digit_sub u_digit (
        .x    (dig_x),
        .y    (dig_y),
        .bin  (br_q),
        .d    (dig_d),
        .bout (dig_bout)
    );

    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (!is_bcd(a[i*DIGIT_W +: DIGIT_W]) || !is_bcd(b[i*DIGIT_W +: DIGIT_W])) begin
                any_bad = 1'b1;
            end
        end
    end

    assign last = (idx_q == IDX_W'(DIGITS - 1));

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        br_d      = br_q;
        a_d       = a_q;
        b_d       = b_q;
        diff_d    = diff_q;
        borrow_d  = borrow_q;
        invalid_d = invalid_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    idx_d    = '0;
                    br_d     = 1'b0;
                    diff_d   = '0;
                    borrow_d = 1'b0;
                    if (any_bad) begin
                        invalid_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        invalid_d = 1'b0;
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                for (int i = 0; i < int'(DIGITS); i++) begin
                    if (idx_q == IDX_W'(i)) diff_d[i*DIGIT_W +: DIGIT_W] = dig_d;
                end
                idx_d = idx_q + IDX_W'(1);
                br_d  = dig_bout;
                if (last) begin
                    borrow_d = dig_bout;
                    idx_d    = '0;
                    br_d     = 1'b0;
`ifdef BCD_SUB_SIGN_MAG_EN
                    state_d  = dig_bout ? CORR : DONE;
`else
                    state_d  = DONE;
`endif
                end
            end
`ifdef BCD_SUB_SIGN_MAG_EN
            CORR: begin
                for (int i = 0; i < int'(DIGITS); i++) begin
                    if (idx_q == IDX_W'(i)) diff_d[i*DIGIT_W +: DIGIT_W] = dig_d;
                end
                idx_d = idx_q + IDX_W'(1);
                br_d  = dig_bout;
                if (last) begin
                    idx_d   = '0;
                    br_d    = 1'b0;
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN) || (state_d == CORR);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            br_q      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            diff_q    <= '0;
            borrow_q  <= 1'b0;
            invalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            br_q      <= br_d;
            a_q       <= a_d;
            b_q       <= b_d;
            diff_q    <= diff_d;
            borrow_q  <= borrow_d;
            invalid_q <= invalid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign diff    = diff_q;
    assign borrow  = borrow_q;
    assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Self-checking bench for bcd_serial_subtractor: directed table, corner sequences, random vs. arithmetic model.
module tb_bcd_serial_subtractor;

    localparam int D = 4;
    localparam int W = 4 * D;
`ifdef BCD_SUB_SIGN_MAG_EN
    localparam bit SM = 1'b1;
`else
    localparam bit SM = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, borrow, invalid;
    logic [W-1:0] diff;

    int errors = 0;
    int checks = 0;

    bcd_serial_subtractor #(.DIGITS(D)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
        .borrow  (borrow),
        .invalid (invalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic [W-1:0] ediff;
        bit           eborrow;
        bit           einvalid;
        bit           hold_start;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r = '0;
        int t = v;
        for (int i = 0; i < D; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Reference: plain integer subtraction on the decimal values.
    function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                  output logic [W-1:0] ed, output bit eb, output bit ei);
        int va, vb, v, m;
        ei = 1'b0;
        for (int i = 0; i < D; i++)
            if (av[i*4 +: 4] > 4'd9 || bv[i*4 +: 4] > 4'd9) ei = 1'b1;
        if (ei) begin
            ed = '0;
            eb = 1'b0;
            return;
        end
        m  = 1;
        for (int i = 0; i < D; i++) m = m * 10;
        va = bcd2int(av);
        vb = bcd2int(bv);
        v  = va - vb;
        eb = (va < vb);
        if (v < 0) v = SM ? -v : v + m;
        ed = int2bcd(v);
    endfunction

    function automatic int exp_latency(input bit eb, input bit ei);
        if (ei) return 1;
        return (SM && eb) ? 2 * D + 1 : D + 1;
    endfunction

    // One full transaction; samples on negedge, start applied for one edge unless held.
    task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] ed, input bit eb, input bit ei, input bit hold);
        int cyc = 0;
        int busy_cnt = 0;
        int lat;
        bit seen = 1'b0;
        lat = exp_latency(eb, ei);
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        cyc = 1;
        if (!hold) start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        if (!ei) check({name, " invalid_cleared"}, 32'(invalid), 32'(0));
        while (cyc < 40) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (!seen) begin
            check({name, " done_timeout"}, 32'(0), 32'(1));
            return;
        end
        check({name, " latency"}, 32'(cyc), 32'(lat));
        check({name, " busy_cycles"}, 32'(busy_cnt), 32'(lat - 1));
        check({name, " busy_at_done"}, 32'(busy), 32'(0));
        check({name, " diff"}, 32'(diff), 32'(ed));
        check({name, " borrow"}, 32'(borrow), 32'(eb));
        check({name, " invalid"}, 32'(invalid), 32'(ei));
        @(negedge clk);
        check({name, " done_pulse"}, {30'd0, busy, done}, 32'(0));
        check({name, " diff_hold"}, 32'(diff), 32'(ed));
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{16'h1234, 16'h0567, 16'h0667, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{16'h0100, 16'h0200, SM ? 16'h0100 : 16'h9900, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{16'h12A4, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'h9999, 16'h9999, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{16'h0000, 16'h0001, SM ? 16'h0001 : 16'h9999, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{16'h0000, 16'h9999, SM ? 16'h9999 : 16'h0001, 1'b1, 1'b0, 1'b0};

        #12;
        check("reset_outputs", {27'd0, busy, done, borrow, invalid, 1'b0} | 32'(diff), 32'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            run_op($sformatf("vec%0d", i), vecs[i].av, vecs[i].bv, vecs[i].ediff,
                   vecs[i].eborrow, vecs[i].einvalid, vecs[i].hold_start);

        // Invalid capture followed by a valid start must clear invalid.
        run_op("inv_then", 16'h0000, 16'h00F0, 16'h0000, 1'b0, 1'b1, 1'b0);
        run_op("valid_after", 16'h0042, 16'h0021, 16'h0021, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of RUN aborts with no done pulse.
        begin
            int dcnt = 0;
            @(negedge clk);
            a = 16'h1234;
            b = 16'h0567;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            @(negedge clk);
            check("pre_reset_busy", 32'(busy), 32'(1));
            rst_n = 1'b0;
            #1;
            check("mid_reset_outputs", {27'd0, busy, done, borrow, invalid, 1'b0} | 32'(diff), 32'(0));
            @(negedge clk);
            rst_n = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (done || busy) dcnt++;
            end
            check("no_done_after_reset", 32'(dcnt), 32'(0));
        end
        run_op("post_reset", 16'h1234, 16'h0567, 16'h0667, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] ra, rb, ed;
            bit eb, ei;
            for (int i = 0; i < D; i++) begin
                ra[i*4 +: 4] = 4'($urandom_range(0, 9));
                rb[i*4 +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 7) == 0) ra[$urandom_range(0, D - 1)*4 +: 4] = 4'($urandom_range(10, 15));
            model(ra, rb, ed, eb, ei);
            run_op($sformatf("rnd%0d_%h_%h", n, ra, rb), ra, rb, ed, eb, ei, $urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
